// File: rtl/trace_dump.sv
// rtl/trace_dump.sv - captures pc and register file on fetch entry and streams a byte frame
// Optional checksum byte: define TRACE_DUMP_CHECKSUM_EN
module trace_dump #(
  parameter logic [7:0] HEADER = 8'hA5,
  parameter int         NREG   = 9
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic [31:0]          pc,
  input  logic [1:0]           state,
  input  logic [32*NREG-1:0]   regs_flat,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic [7:0]           drop_cnt
);

  // Payload is pc followed by x0..x(NREG-1), four bytes each
  localparam int PLEN = 4 * (NREG + 1);
  localparam int IW   = $clog2(PLEN);
  localparam int SW   = 32 * (NREG + 1);

`ifdef TRACE_DUMP_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_CSUM} fsm_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD} fsm_t;
`endif

  fsm_t          fsm_q;
  fsm_t          fsm_d;
  logic [1:0]    prev_state;
  logic          armed;
  logic [IW-1:0] idx;
  logic [SW-1:0] snap;
  logic [SW-1:0] snap_shifted;
  logic [7:0]    cur_byte;
  logic          trig;
  logic          last_byte;
  logic          capture;
  logic          pay_xfer;

  // Trigger on entry into fetch; armed blocks the first edge after reset release
  assign trig      = armed && en && (state == 2'd0) && (prev_state != 2'd0);
  assign capture   = (fsm_q == S_IDLE) && trig;
  assign pay_xfer  = (fsm_q == S_PAYLOAD) && tx_ready;
  assign last_byte = (idx == IW'(PLEN - 1));

  // Snapshot is laid out so that byte n of the payload is simply snap[8n+7:8n]
  assign snap_shifted = snap >> {idx, 3'b000};
  assign cur_byte     = snap_shifted[7:0];

  // Previous pipeline state and reset-release arming
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_state <= 2'd1;
      armed      <= 1'b0;
    end else begin
      prev_state <= state;
      armed      <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) fsm_q <= S_IDLE;
    else       fsm_q <= fsm_d;
  end

  // FSM next-state: advance only on accepted bytes
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:    if (trig) fsm_d = S_HDR;
      S_HDR:     if (tx_ready) fsm_d = S_PAYLOAD;
`ifdef TRACE_DUMP_CHECKSUM_EN
      S_PAYLOAD: if (tx_ready && last_byte) fsm_d = S_CSUM;
      S_CSUM:    if (tx_ready) fsm_d = S_IDLE;
`else
      S_PAYLOAD: if (tx_ready && last_byte) fsm_d = S_IDLE;
`endif
      default:   fsm_d = S_IDLE;
    endcase
  end

  // Snapshot capture and payload byte index
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      snap <= '0;
      idx  <= '0;
    end else if (capture) begin
      snap <= {regs_flat, pc};
      idx  <= '0;
    end else if (pay_xfer) begin
      idx  <= last_byte ? '0 : idx + 1'b1;
    end
  end

`ifdef TRACE_DUMP_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR over payload bytes as they are accepted
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         csum <= 8'h00;
    else if (capture)  csum <= 8'h00;
    else if (pay_xfer) csum <= csum ^ cur_byte;
  end
`endif

  // Saturating count of triggers that arrive while a frame is in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      drop_cnt <= 8'h00;
    else if (trig && (fsm_q != S_IDLE) && (drop_cnt != 8'hFF))
      drop_cnt <= drop_cnt + 8'h01;
  end

  // FSM outputs: decoded from state so reset clears them without waiting for an edge
  always_comb begin
    tx_valid = (fsm_q != S_IDLE);
    busy     = (fsm_q != S_IDLE);
    tx_data  = 8'h00;
    case (fsm_q)
      S_HDR:     tx_data = HEADER;
      S_PAYLOAD: tx_data = cur_byte;
`ifdef TRACE_DUMP_CHECKSUM_EN
      S_CSUM:    tx_data = csum;
`endif
      default:   tx_data = 8'h00;
    endcase
  end

endmodule
